// File: rtl/seq_detect_multi.sv
// seq_detect_multi
//   Serial multi-pattern sequence detector. Shifts din into a history register
//   on each din_vld beat. It compares the history against NUM_PAT
//   runtime-programmable patterns, and each pattern has its own length.
//   Matches come out as a registered one-cycle pulse per slot. A saturating
//   counter records how many beats matched at least one slot.
//
// Ports
//   clk, rst_n      clock (rising edge), asynchronous active-low reset
//   clear           sync clear of fill, match outputs and counter
//   mode_overlap    1 = overlapping detection, 0 = non-overlapping
//   cfg_we/idx/pat/len/en   pattern slot write port (bit0 = most recent bit)
//   din_vld, din    serial input bit and its qualifier
//   match           one-cycle pulse, some slot matched on the previous beat
//   match_id        per-slot mask of the slots that matched
//   match_cnt       saturating count of matching beats
module seq_detect_multi #(
    parameter int SEQ_WIDTH = 8,
    parameter int NUM_PAT   = 4,
    parameter int CNT_WIDTH = 16,
    parameter logic [NUM_PAT*SEQ_WIDTH-1:0] INIT_PAT =
        {8'h00, 8'h00, 8'b00101110, 8'b00111000},
    parameter int INIT_LEN  = 6,
    parameter logic [NUM_PAT-1:0] INIT_EN = 4'b0011,
    localparam int IDX_W = (NUM_PAT > 1) ? $clog2(NUM_PAT) : 1,
    localparam int LEN_W = $clog2(SEQ_WIDTH + 1)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 clear,
    input  logic                 mode_overlap,
    input  logic                 cfg_we,
    input  logic [IDX_W-1:0]     cfg_idx,
    input  logic [SEQ_WIDTH-1:0] cfg_pat,
    input  logic [LEN_W-1:0]     cfg_len,
    input  logic                 cfg_en,
    input  logic                 din_vld,
    input  logic                 din,
    output logic                 match,
    output logic [NUM_PAT-1:0]   match_id,
    output logic [CNT_WIDTH-1:0] match_cnt
);

    localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;
    localparam logic [LEN_W-1:0]     FILL_MAX = LEN_W'(SEQ_WIDTH);

    logic [SEQ_WIDTH-1:0] hist_q, hist_d;
    logic [LEN_W-1:0]     fill_q, fill_d;
    logic [NUM_PAT-1:0]   match_id_q;
    logic [CNT_WIDTH-1:0] cnt_q;
    logic [NUM_PAT-1:0]   hit;

    // History as it will be after this beat, so the bit arriving now takes
    // part in the comparison.
    assign hist_d = {hist_q[SEQ_WIDTH-2:0], din};

    for (genvar i = 0; i < NUM_PAT; i++) begin : g_slot
        logic [SEQ_WIDTH-1:0] pat_q;
        logic [LEN_W-1:0]     len_q;
        logic                 en_q;
        logic [LEN_W-1:0]     l_eff;
        logic [SEQ_WIDTH-1:0] mask;

        // A programmed length beyond the history depth is clamped to it.
        always_comb begin
            l_eff = (len_q > FILL_MAX) ? FILL_MAX : len_q;
            mask  = '0;
            for (int b = 0; b < SEQ_WIDTH; b++)
                mask[b] = (b < int'(l_eff));
        end

        // Fill counts valid bits since reset, clear or a non-overlap match.
        // The +1 counts the current bit, so stale history never matches.
        assign hit[i] = din_vld && en_q && (l_eff != '0) &&
                        (({1'b0, fill_q} + (LEN_W+1)'(1)) >= {1'b0, l_eff}) &&
                        (((hist_d ^ pat_q) & mask) == '0);

        // Out-of-range cfg_idx values match no slot and are dropped.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                pat_q <= INIT_PAT[i*SEQ_WIDTH +: SEQ_WIDTH];
                len_q <= LEN_W'(INIT_LEN);
                en_q  <= INIT_EN[i];
            end else if (cfg_we && cfg_idx == IDX_W'(i)) begin
                pat_q <= cfg_pat;
                len_q <= cfg_len;
                en_q  <= cfg_en;
            end
        end
    end

    always_comb begin
        fill_d = fill_q;
        if (!mode_overlap && |hit)
            fill_d = '0;
        else if (fill_q != FILL_MAX)
            fill_d = fill_q + LEN_W'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hist_q     <= '0;
            fill_q     <= '0;
            match_id_q <= '0;
            cnt_q      <= '0;
        end else if (clear) begin
            // Clear wins over a same-cycle beat: the bit is dropped.
            fill_q     <= '0;
            match_id_q <= '0;
            cnt_q      <= '0;
        end else begin
            match_id_q <= hit;
            if (din_vld) begin
                hist_q <= hist_d;
                fill_q <= fill_d;
            end
            if (|hit && cnt_q != CNT_MAX)
                cnt_q <= cnt_q + CNT_WIDTH'(1);
        end
    end

    assign match     = |match_id_q;
    assign match_id  = match_id_q;
    assign match_cnt = cnt_q;

endmodule
